// File: rtl/instruction_prefetch.sv
// Fetch unit: owns the fetch PC, streams sequential words into a small prefetch FIFO,
// and shares the single memory port with execute-stage data accesses (data wins).
module instruction_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] mem_address,
    output logic        mem_mode,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        data_req,
    input  logic        data_mode,
    input  logic [31:0] data_address,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_address,
    output logic        instr_valid,
    output logic [31:0] instr_word,
    output logic [31:0] instr_address,
    input  logic        instr_ready
);
    localparam int              PW         = $clog2(DEPTH);
    localparam logic [PW:0]     FULL_COUNT = DEPTH[PW:0];
    localparam logic [PW:0]     ONE_COUNT  = 1;
    localparam logic [PW-1:0]   ONE_PTR    = 1;

    logic [31:0]   word_q [DEPTH];
    logic [31:0]   addr_q [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic [31:0]   fetch_pc;

    logic data_active;
    logic store;
    logic pop;
    logic push;

    // Data accesses are masked during reset so no write can reach memory.
    assign data_active = data_req && !reset;
    assign store       = data_active && data_mode;

    assign mem_address = data_active ? data_address : fetch_pc;
    assign mem_mode    = data_active ? data_mode : 1'b0;
    assign mem_wdata   = data_active ? data_wdata : 32'h0;
    assign data_rdata  = mem_rdata;

    // Handshake: the head transfers when instr_valid && instr_ready in a cycle without
    // redirect; during a redirect the head is still shown but never consumed.
    assign instr_valid   = (count != '0);
    assign instr_word    = word_q[rd_ptr];
    assign instr_address = addr_q[rd_ptr];

    assign pop  = instr_valid && instr_ready && !redirect_valid;
    assign push = !reset && !data_req && !redirect_valid && ((count < FULL_COUNT) || pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= 32'h0;
                addr_q[i] <= 32'h0;
            end
        end else if (redirect_valid) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= redirect_address;
        end else if (store) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            // FIFO contents are contiguous, so refetch from the oldest surviving entry.
            if (pop) begin
                if (count > ONE_COUNT) begin
                    fetch_pc <= addr_q[rd_ptr + ONE_PTR];
                end
            end else if (count != '0) begin
                fetch_pc <= addr_q[rd_ptr];
            end
        end else begin
            if (push) begin
                word_q[wr_ptr] <= mem_rdata;
                addr_q[wr_ptr] <= fetch_pc;
                wr_ptr         <= wr_ptr + ONE_PTR;
                fetch_pc       <= fetch_pc + 32'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
            case ({push, pop})
                2'b10:   count <= count + ONE_COUNT;
                2'b01:   count <= count - ONE_COUNT;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: doc/instruction_prefetch.md
Name: instruction_prefetch

Overview:
- Sits between the flip-flop instruction/data memory and the decode stage.
- Owns the fetch PC and streams sequential 32-bit words, both instructions and trailing immediates, into a small prefetch FIFO. Decode drains the FIFO with a valid/ready handshake.
- Arbitrates the memory's single combinational port between fetch and execute-stage data accesses; data accesses have priority.
- Handles jump redirects and flushes on stores.

Parameters:
DEPTH, 4, prefetch FIFO entries (power of two, >=2)
RESET_PC, 32'h0, word address fetched first after reset

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-high
mem_address  out  32  word address to memory address_in
mem_mode  out  1  to memory mode (1 write, 0 read)
mem_wdata  out  32  to memory data_in
mem_rdata  in  32  from memory data_out (combinational read)
data_req  in  1  execute stage requests memory this cycle
data_mode  in  1  1 write, 0 read
data_address  in  32  data word address
data_wdata  in  32  store data
data_rdata  out  32  load data, same cycle, equals mem_rdata
redirect_valid  in  1  jump taken, one-cycle pulse
redirect_address  in  32  jump target word address
instr_valid  out  1  FIFO head valid
instr_word  out  32  FIFO head word
instr_address  out  32  word address of FIFO head
instr_ready  in  1  decode consumes head when instr_valid&&instr_ready

Behaviour:
- Reset values: FIFO empty (count=0, rd/wr ptr=0); fetch_pc=RESET_PC; instr_valid=0; instr_word=0; instr_address=0.
- During reset:
  - mem_mode forced 0; no memory write can occur.
  - mem_wdata=0; mem_address=fetch_pc.
  - data_req is ignored.
- Port mux, combinational, evaluated every cycle:
  - data_req=1: mem_address=data_address, mem_mode=data_mode, mem_wdata=data_wdata.
  - Otherwise: mem_address=fetch_pc, mem_mode=0, mem_wdata=0.
  - data_rdata=mem_rdata always.
- pop = instr_valid && instr_ready && !redirect_valid.
- push = !reset && !data_req && !redirect_valid && (count<DEPTH || pop).
  - A push writes {fetch_pc, mem_rdata} at the tail and sets fetch_pc<=fetch_pc+1.
  - fetch_pc wraps 32'hFFFFFFFF to 0.
- Simultaneous push and pop while full is legal; count is unchanged.
- FIFO outputs come from the registered head. A word fetched in cycle N is visible on instr_* from cycle N+1.
- Redirect (redirect_valid=1), highest priority:
  - FIFO cleared, fetch_pc<=redirect_address.
  - No pop; instr_valid is still shown but the consumer must ignore the head that cycle.
  - No push.
  - First target word is fetched in cycle N+1 (if data_req=0) and presented at N+2.
- Store flush (data_req=1 && data_mode=1, no redirect), protects against stale prefetched code:
  - FIFO cleared.
  - fetch_pc<=head instr_address if count>0 after any same-cycle pop. Otherwise fetch_pc is unchanged.
  - With a same-cycle pop, rewind to the entry after the popped head. If none remains, fetch_pc is unchanged.
  - The write itself is always performed.
- Redirect together with a store: the store goes to memory, the FIFO is cleared, and fetch_pc<=redirect_address.
- Data read (data_req=1, data_mode=0): fetch is stalled for that cycle; the FIFO is untouched except for pop.
- Out-of-range fetch addresses need no special handling; memory returns 0 and the word is queued normally.
- Throughput: one word per cycle with instr_ready held 1 and no data traffic.

Test Plan:
- Reset release, RESET_PC=0, memory[0..3]=10,11,12,13, instr_ready=1 → instr_valid rises one cycle after reset drops. instr_word sequence 10,11,12,13 on consecutive cycles; instr_address 0,1,2,3.
- instr_ready=0 for 10 cycles after reset (DEPTH=4) → fetch stops after 4 pushes, fetch_pc=4, head word=memory[0]. Raising ready yields memory[0..3] then memory[4] with no gaps.
- FIFO holding addresses 5..8, pulse redirect_valid to 48 → next cycle count=0. Two cycles after the pulse: instr_address=48, instr_word=memory[48]. No word from 5..8 is ever consumed afterwards.
- data_req=1 read of address 60 for 3 cycles while streaming → data_rdata=memory[60] each cycle, mem_mode=0, fetch_pc frozen. Streaming resumes with no skipped or duplicated address.
- Store of 32'hDEADBEEF to address 9 with FIFO holding 7..10, no pop → memory[9] updated, FIFO cleared, fetch_pc=7. Later instr_address 9 shows DEADBEEF.
- Redirect and store in the same cycle, target 12 → store lands, next consumed instr_address=12. Assert reset mid-stream: instr_valid=0 next cycle, mem_mode=0 even with data_req=1, data_mode=1.
